// File: rtl/decoder_pipe_pkg.sv
// Shared ops definitions for the decode stage: opcode encodings and instruction field positions.
package decoder_pipe_pkg;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned REG_W    = 3;

    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned RD_LSB     = 9;
    localparam int unsigned MODE_BIT   = 8;
    localparam int unsigned RA_MSB     = 7;
    localparam int unsigned RA_LSB     = 5;
    localparam int unsigned RB_MSB     = 4;
    localparam int unsigned RB_LSB     = 2;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_OR     = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_AND    = 4'b0100,
        OP_NOT    = 4'b0101,
        OP_READ   = 4'b0110,
        OP_WRITE  = 4'b0111,
        OP_LOAD   = 4'b1000,
        OP_CMP    = 4'b1001,
        OP_SHL    = 4'b1010,
        OP_SHR    = 4'b1011,
        OP_JUMP   = 4'b1100,
        OP_JUMPEQ = 4'b1101
    } opcode_e;

    // Register-select and control fields of one decoded instruction (immediate/PC stored alongside).
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    ra;
        logic [REG_W-1:0]    rb;
        logic                mode;
    } fields_t;

endpackage

// File: rtl/decoder_pipe_decode_fields.sv
// Combinational field extraction and immediate formation for one 16-bit instruction.
module decode_fields
    import decoder_pipe_pkg::*;
#(
    parameter int unsigned IMM_W    = 16,
    parameter bit          SEXT_IMM = 1'b1
) (
    input  logic [INSTR_W-1:0] instr,
    output fields_t            fields,
    output logic [IMM_W-1:0]   imm
);

    logic [7:0] write_imm;
    logic [7:0] low_imm;

    assign fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign fields.rd     = instr[RD_MSB:RD_LSB];
    assign fields.ra     = instr[RA_MSB:RA_LSB];
    assign fields.rb     = instr[RB_MSB:RB_LSB];
    assign fields.mode   = instr[MODE_BIT];

    // WRITE packs rD and the low three bits into a word-aligned byte.
    assign write_imm = {instr[11:9], instr[2:0], 2'b00};
    assign low_imm   = instr[7:0];

    always_comb begin
        imm = '0;
        if (instr[OPCODE_MSB:OPCODE_LSB] == OP_WRITE) begin
            imm = IMM_W'(write_imm);
        end else if (SEXT_IMM && instr[MODE_BIT]) begin
            imm = IMM_W'($signed(low_imm));
        end else begin
            imm = IMM_W'(low_imm);
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// Decode stage with valid/ready on both sides and a DEPTH-entry queue of decoded instructions.
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PC_W     = 16,
    parameter int unsigned IMM_W    = 16,
    parameter bit          SEXT_IMM = 1'b1
) (
    input  logic                         I_clk,
    input  logic                         I_reset_n,
    input  logic                         I_enable,
    input  logic                         I_flush,
    input  logic                         I_valid,
    output logic                         O_ready,
    input  logic [INSTR_W-1:0]           I_instruction,
    input  logic [PC_W-1:0]              I_pc,
    output logic                         O_valid,
    input  logic                         I_ready,
    output logic [OPCODE_W-1:0]          O_opcode,
    output logic [REG_W-1:0]             O_rD_select,
    output logic [REG_W-1:0]             O_rA_select,
    output logic [REG_W-1:0]             O_rB_select,
    output logic                         O_mode,
    output logic [IMM_W-1:0]             O_immediate,
    output logic [PC_W-1:0]              O_pc,
    output logic [$clog2(DEPTH+1)-1:0]   O_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    fields_t          fld_q [DEPTH];
    logic [IMM_W-1:0] imm_q [DEPTH];
    logic [PC_W-1:0]  pc_q  [DEPTH];

    fields_t          dec_fields;
    logic [IMM_W-1:0] dec_imm;
    logic             push;
    logic             pop;

    decode_fields #(
        .IMM_W    (IMM_W),
        .SEXT_IMM (SEXT_IMM)
    ) u_decode (
        .instr  (I_instruction),
        .fields (dec_fields),
        .imm    (dec_imm)
    );

    // Ready is held low during reset so every output reads 0 while rst_n is asserted.
    assign O_ready = I_reset_n && I_enable && !I_flush && (count < CNT_W'(DEPTH));
    assign O_valid = (count != '0);
    assign push    = I_valid && O_ready;
    assign pop     = O_valid && I_ready && I_enable && !I_flush;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fld_q[i] <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (I_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fld_q[wr_ptr] <= dec_fields;
                imm_q[wr_ptr] <= dec_imm;
                pc_q[wr_ptr]  <= I_pc;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign O_opcode    = fld_q[rd_ptr].opcode;
    assign O_rD_select = fld_q[rd_ptr].rd;
    assign O_rA_select = fld_q[rd_ptr].ra;
    assign O_rB_select = fld_q[rd_ptr].rb;
    assign O_mode      = fld_q[rd_ptr].mode;
    assign O_immediate = imm_q[rd_ptr];
    assign O_pc        = pc_q[rd_ptr];
    assign O_count     = count;

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
Parametrised successor to the single-register instruction decoder. It adds a valid/ready handshake on both sides, a DEPTH-entry decoded-instruction queue, PC passthrough, a flush input, and configurable immediate width and extension. It sits between fetch and the ALU/register-file stage. It absorbs back-pressure without losing instructions.

Parameters:
- DEPTH, 2, queue entries; power of two, minimum 2.
- PC_W, 16, width of the PC carried alongside each instruction.
- IMM_W, 16, output immediate width; minimum 8.
- SEXT_IMM, 1, when 1, non-WRITE immediates with mode bit set are sign-extended.

Ports:
- I_clk  in  1  clock, rising edge.
- I_reset_n  in  1  asynchronous, active-low reset.
- I_enable  in  1  global run; 0 freezes the block.
- I_flush  in  1  synchronous queue clear.
- I_valid  in  1  fetch presents an instruction.
- O_ready  out  1  block accepts the instruction this cycle.
- I_instruction  in  16  raw instruction.
- I_pc  in  PC_W  address of I_instruction.
- O_valid  out  1  head entry valid.
- I_ready  in  1  downstream consumes the head entry.
- O_opcode  out  4  instr[15:12].
- O_rD_select  out  3  instr[11:9].
- O_rA_select  out  3  instr[7:5].
- O_rB_select  out  3  instr[4:2].
- O_mode  out  1  instr[8].
- O_immediate  out  IMM_W  formed immediate.
- O_pc  out  PC_W  PC of the head entry.
- O_count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (async assert, sync release):
  - count, write pointer and read pointer go to 0.
  - All storage is cleared to 0.
  - All outputs are 0, including O_valid, O_ready and O_count.
- Handshake:
  - push = I_valid && O_ready.
  - pop = O_valid && I_ready && I_enable && !I_flush.
  - O_ready = I_enable && !I_flush && (count < DEPTH). O_ready is registered-state based; there is no same-cycle full pass-through.
- Decode is combinational on I_instruction. The decoded fields plus I_pc are written into the queue on push.
- Immediate formation:
  - Opcode WRITE: the 8-bit value {instr[11:9], instr[2:0], 2'b00}, zero-extended to IMM_W.
  - Other opcodes: instr[7:0]. Sign-extended to IMM_W when SEXT_IMM=1 and instr[8]=1; otherwise zero-extended.
- Latency: an instruction pushed at edge N appears with O_valid=1 after edge N. Throughput is 1 instruction per cycle while neither full nor stalled.
- Outputs come from registered storage at the read pointer. They are stable while O_valid && !I_ready.
- O_valid = (count != 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full (count==DEPTH): O_ready=0. A pop in that cycle frees one entry; the next push can occur on the following cycle.
- Empty: O_valid=0. I_ready is ignored.
- Pointers are clog2(DEPTH) bits and wrap naturally.
- I_flush=1:
  - Flush has priority over everything.
  - At the next edge: count=0, pointers=0, O_valid=0.
  - No push or pop occurs in the flush cycle.
  - Storage contents need not be cleared.
- I_enable=0 (and no flush): no push, no pop. State and outputs hold.
- Reset mid-operation: all queued entries are lost immediately and outputs drop to 0 asynchronously.

Decomposition:
- Shared ops package (existing ops header): opcode encodings including WRITE, and instruction field bit positions.
- Sub-module decode_fields: purely combinational. Maps a 16-bit instruction to opcode, rD, rA, rB, mode and immediate, with IMM_W/SEXT_IMM parameters.
- Queue storage, pointers and count stay inline in decoder_pipe.

Test Plan:
- Reset, then one push of WRITE with instr[11:9]=101 and instr[2:0]=011 -> next cycle: O_valid=1, O_immediate=0x00AC, O_rD_select=101, O_count=1.
- Non-WRITE instr[11:0]=0x3F0, SEXT_IMM=1 -> O_rD_select=001, O_mode=1, O_rA_select=111, O_rB_select=100, O_immediate=0xFFF0. Same with SEXT_IMM=0 -> O_immediate=0x00F0.
- I_ready=0, push DEPTH=2 instructions (PC 0x10, 0x12) -> O_ready=0 and O_count=2; third instruction not accepted. Raise I_ready -> outputs 0x10 then 0x12 in order, with no loss or duplication.
- Continuous I_valid=1 and I_ready=1 over 8 instructions -> one output per cycle, PCs in order, O_count stays at 1.
- Queue holds 2 entries; assert I_flush with I_valid=1 -> next cycle O_valid=0, O_count=0, and the flush-cycle instruction is dropped.
- I_enable=0 with a valid head and I_ready=1 -> head held, O_count unchanged. Assert I_reset_n=0 mid-stream -> O_valid=0 and O_count=0 immediately, without waiting for a clock edge.
